// File: rtl/dmem_lsu.sv
// Load/store initiator between the core and a word-wide data memory: sub-word stores
// use read-modify-write, sub-word loads are sign/zero extended. Optional alignment checking via LSU_ALIGN_CHECK_EN.

module dmem_lsu_lane (
  input  logic       en,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] merged
);
  assign merged = en ? new_b : old_b;
endmodule

module dmem_lsu #(
  parameter int MEM_AW = 10,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsgn,
  input  logic [MEM_AW+1:0] addr,
  input  logic [DW-1:0]     wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DW-1:0]     load_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);
  localparam int NUM_LANES = DW / 8;

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
  state_t state;

  logic                         we_q;
  logic [1:0]                   size_q;
  logic                         unsgn_q;
  logic [1:0]                   off_q;
  logic [DW-1:0]                wdata_q;

  logic                         misalign;
  logic [NUM_LANES-1:0]         be;
  logic [NUM_LANES-1:0][7:0]    rd_b, rep_b, mrg_b;
  logic [15:0]                  hw;
  logic [DW-1:0]                ext;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign rd_b = mem_rdata;

  // Store data is replicated across lanes; the byte enables pick which lanes take it.
  always_comb begin
    be    = '0;
    rep_b = wdata_q;
    case (size_q)
      2'b00: begin
        be[off_q] = 1'b1;
        rep_b     = {NUM_LANES{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = off_q[1] ? 4'b1100 : 4'b0011;
        rep_b = {2{wdata_q[15:0]}};
      end
      default: be = '1;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dmem_lsu_lane u_lane (
      .en     (be[i]),
      .old_b  (rd_b[i]),
      .new_b  (rep_b[i]),
      .merged (mrg_b[i])
    );
  end

  always_comb begin
    hw  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext = mem_rdata;
    case (size_q)
      2'b00:   ext = {{24{~unsgn_q & rd_b[off_q][7]}}, rd_b[off_q]};
      2'b01:   ext = {{16{~unsgn_q & hw[15]}}, hw};
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_data <= '0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      unsgn_q   <= 1'b0;
      off_q     <= 2'b00;
      wdata_q   <= '0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: if (req) begin
          we_q     <= we;
          size_q   <= size;
          unsgn_q  <= unsgn;
          off_q    <= addr[1:0];
          wdata_q  <= wdata;
          mem_addr <= addr[MEM_AW+1:2];
          busy     <= 1'b1;
          if (size == 2'b11 || misalign) begin
            state <= FIN;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (we && size == 2'b10) begin
            state     <= WR;
            mem_write <= 1'b1;
            mem_wdata <= wdata;
          end else begin
            state    <= RD;
            mem_read <= 1'b1;
          end
        end
        RD: begin
          // The merged word is captured here so WR drives a registered write word.
          if (we_q) begin
            state     <= WR;
            mem_write <= 1'b1;
            mem_wdata <= mrg_b;
          end else begin
            state     <= FIN;
            done      <= 1'b1;
            load_data <= ext;
          end
        end
        WR: begin
          state <= FIN;
          done  <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural word memory.

module tb_dmem_lsu;
  logic        clk = 1'b0;
  logic        rst_n, req, we, unsgn;
  logic [1:0]  size;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err, mem_read, mem_write;
  logic [31:0] load_data, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  logic [31:0] mem [1024];
  int total = 0, bad = 0;
  int lat, rd_cnt, wr_cnt, done_cnt;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err_at_done;

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .unsgn(unsgn),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to done, recording latency and memory traffic.
  task automatic op(input logic w, input logic [1:0] sz, input logic u,
                    input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; unsgn = u; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    lat = 1; rd_cnt = 0; wr_cnt = 0; err_at_done = 1'bx;
    forever begin
      if (mem_read) rd_cnt++;
      if (mem_write) begin wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (done) begin err_at_done = err; break; end
      if (lat >= 8) begin check("timeout", 32'(lat), 32'd0); break; end
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; unsgn = 1'b0;
    addr = '0; wdata = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mrd", mem_read, 0);
    check("rst_mwr", mem_write, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_mwd", mem_wdata, 0);
    check("rst_ld", load_data, 0);
    @(negedge clk); rst_n = 1'b1;

    op(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF);
    check("sw_lat", lat, 2);
    check("sw_err", err_at_done, 0);
    check("sw_wr", wr_cnt, 1);
    check("sw_rd", rd_cnt, 0);
    check("sw_addr", wr_addr, 4);
    check("sw_data", wr_data, 32'hDEADBEEF);
    @(negedge clk);
    check("sw_busy_after", busy, 0);
    check("sw_mem", mem[4], 32'hDEADBEEF);

    op(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    check("lw_lat", lat, 2);
    check("lw_rd", rd_cnt, 1);
    check("lw_wr", wr_cnt, 0);
    check("lw_data", load_data, 32'hDEADBEEF);

    op(1'b1, 2'b00, 1'b0, 12'h012, 32'h00000055);
    check("sb_lat", lat, 3);
    check("sb_rd", rd_cnt, 1);
    check("sb_wr", wr_cnt, 1);
    check("sb_data", wr_data, 32'hDE55BEEF);

    op(1'b0, 2'b00, 1'b0, 12'h013, 32'h0);
    check("lb", load_data, 32'hFFFFFFDE);
    op(1'b0, 2'b00, 1'b1, 12'h013, 32'h0);
    check("lbu", load_data, 32'h000000DE);
    op(1'b0, 2'b01, 1'b0, 12'h010, 32'h0);
    check("lh", load_data, 32'hFFFFBEEF);
    op(1'b0, 2'b01, 1'b1, 12'h012, 32'h0);
    check("lhu", load_data, 32'h0000DE55);
    check("lhu_lat", lat, 2);

    op(1'b0, 2'b11, 1'b0, 12'h010, 32'h0);
    check("rsv_lat", lat, 1);
    check("rsv_err", err_at_done, 1);
    check("rsv_rd", rd_cnt, 0);
    check("rsv_wr", wr_cnt, 0);
    check("rsv_ld_held", load_data, 32'h0000DE55);

    op(1'b0, 2'b10, 1'b0, 12'h011, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    check("mis_lat", lat, 1);
    check("mis_err", err_at_done, 1);
    check("mis_rd", rd_cnt, 0);
    check("mis_ld_held", load_data, 32'h0000DE55);
`else
    check("mis_lat", lat, 2);
    check("mis_err", err_at_done, 0);
    check("mis_rd", rd_cnt, 1);
    check("mis_ld", load_data, 32'hDE55BEEF);
`endif

    // SH at offset 0 with a second request pulsed during RD.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b01; unsgn = 1'b0; addr = 12'h010; wdata = 32'h00001234;
    @(negedge clk);
    check("sh_in_rd", mem_read, 1);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 12'h020; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("sh_one_done", done_cnt, 1);
    check("sh_mem", mem[4], 32'hDE551234);
    check("sh_ignored", mem[8], 32'h0);

    op(1'b0, 2'b00, 1'b1, 12'h010, 32'h0);
    check("lbu_off0", load_data, 32'h00000034);

    // Reset asserted while a byte store is in its read phase.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 12'h011; wdata = 32'h000000AA;
    @(negedge clk);
    req = 1'b0;
    check("rr_in_rd", mem_read, 1);
    rst_n = 1'b0;
    #1;
    check("rr_busy", busy, 0);
    check("rr_mrd", mem_read, 0);
    check("rr_mwr", mem_write, 0);
    check("rr_maddr", mem_addr, 0);
    check("rr_ld", load_data, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rr_mem", mem[4], 32'hDE551234);
    check("rr_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator that sits between the single-cycle CPU datapath and the word-wide data memory.
- Accepts byte-addressed load and store requests of byte, halfword or word size from the core.
- Drives the memory's memread/memwrite/address/write_data side and captures read_data.
- Performs read-modify-write for sub-word stores, and sign- or zero-extension for sub-word loads. The memory itself stores only whole 32-bit words at a 10-bit word address.

Parameters:
- MEM_AW, 10, memory word-address width; the byte address is MEM_AW+2 bits.
- DW, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  request strobe; sampled only when busy=0.
- we  input  1  1=store, 0=load.
- size  input  2  00=byte, 01=half, 10=word, 11=reserved.
- unsgn  input  1  loads only: 1=zero-extend, 0=sign-extend.
- addr  input  MEM_AW+2  byte address.
- wdata  input  32  store data; the sub-word value is in the low bits.
- busy  output  1  high from the cycle after acceptance until the done cycle inclusive.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = request rejected, no memory write performed.
- load_data  output  32  extended load result; updated at done of a successful load, otherwise held.
- mem_read  output  1  to memory memread.
- mem_write  output  1  to memory memwrite.
- mem_addr  output  MEM_AW  to memory address, equal to addr[MEM_AW+1:2] of the latched request.
- mem_wdata  output  32  to memory write_data.
- mem_rdata  input  32  from memory read_data; combinational, valid in the same cycle as mem_read.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, err, mem_read, mem_write = 0.
  - mem_addr=0, mem_wdata=0, load_data=0.
  - Internal request latches = 0.
- Acceptance: in IDLE with req=1, the edge latches we/size/unsgn/addr/wdata. All later cycles use the latched copies.
- Byte lanes are little-endian:
  - byte offset k occupies bits [8k+7:8k];
  - a halfword at offset 0 occupies [15:0], at offset 2 occupies [31:16].
- FSM states: IDLE, RD, WR, FIN.
  - IDLE -> RD: load, or store with size 00/01.
  - IDLE -> WR: store with size 10.
  - IDLE -> FIN: rejected request (size 11, or misaligned when checking is enabled).
  - RD: mem_read=1. At the edge, mem_rdata is captured into a word register. Next state is WR for a sub-word store, FIN for a load.
  - WR: mem_write=1 and mem_wdata = merged word; memory writes at the end of this cycle.
    - Word store: merged word = wdata.
    - Sub-word store: captured word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - FIN: done=1 and err valid. For a successful load, load_data = the extracted lane, extended per unsgn (word loads are returned unchanged). Next state is IDLE.
- mem_read and mem_write are registered, never both high, and high only in RD and WR respectively. mem_addr is held through the whole operation.
- Latency, counted from the accept edge to the cycle in which done=1:
  - word store: 2 cycles;
  - load of any size: 2 cycles;
  - byte or half store: 3 cycles;
  - rejected request: 1 cycle.
- Back-to-back: req may be asserted in the FIN cycle but is ignored there. The earliest acceptance is the edge that ends the cycle after FIN, i.e. when busy=0.
- req while busy=1 is ignored; there is no queue.
- Reserved size 11 always gives err=1 with no memory access and load_data unchanged.
- Reset mid-operation: the FSM returns to IDLE immediately and mem_write drops asynchronously. A sub-word store interrupted in RD leaves memory unmodified.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]!=0, is rejected.
  - A rejected request performs no memory access and gives done with err=1 one cycle after accept.
  - load_data is held.
- Not defined:
  - No alignment errors are raised.
  - A halfword uses only addr[1] to select its lane (addr[0] is ignored).
  - A word ignores addr[1:0].
  - Only size 11 produces err.

Test Plan:
- Word store then load:
  - SW addr=0x010, wdata=0xDEADBEEF -> mem_write high one cycle with mem_addr=4, mem_wdata=0xDEADBEEF; done 2 cycles after accept; err=0.
  - LW addr=0x010 -> done 2 cycles after accept; load_data=0xDEADBEEF.
- Byte RMW: word 4 = 0xDEADBEEF; SB addr=0x012, wdata=0x55 -> RD then WR with mem_wdata=0xDE55BEEF; done 3 cycles after accept.
- Sub-word loads, word 4 = 0xDE55BEEF:
  - LB 0x013 -> 0xFFFFFFDE.
  - LBU 0x013 -> 0x000000DE.
  - LH 0x010 -> 0xFFFFBEEF.
  - LHU 0x012 -> 0x0000DE55.
- Error paths:
  - size=11 -> done+err one cycle after accept, no mem_read or mem_write.
  - With LSU_ALIGN_CHECK_EN: LW 0x011 -> err=1, no mem access.
  - Without LSU_ALIGN_CHECK_EN: LW 0x011 reads word 4.
- Busy and reset:
  - Second req pulsed during RD of an SH -> ignored; exactly one done.
  - rst_n=0 asserted during RD of an SB -> all outputs 0 at once; memory word unchanged.
